// File: rtl/pixel_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_seq_pkg
//  Description : Shared types and default geometry for the pixel beat
//                sequencer. It holds the FSM state encoding, the default
//                frame geometry, the beat/idle counter width and a preload
//                helper for the idle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_seq_pkg;

  // Width of the beat index and of all three down-counters.
  localparam int BEAT_W = 8;

  // Default geometry.
  localparam int          DEF_ADDR_W    = 20;
  localparam int          DEF_COORD_W   = 10;
  localparam int          DEF_IMG_W     = 16;
  localparam int          DEF_IMG_H     = 16;
  localparam int          DEF_ROW_PITCH = 16;
  localparam int unsigned DEF_BASE_ADDR = 0;
  localparam int          DEF_BEATS     = 4;
  localparam int          DEF_PAUSE     = 1;
  localparam int          DEF_ROW_GAP   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT  = 3'd1,
    ST_PAUSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // A phase of n cycles loads n-1 and leaves when the counter reads zero.
  // A zero-length phase is never entered, so its preload is irrelevant.
  function automatic logic [BEAT_W-1:0] cnt_preload(input int n);
    return (n > 0) ? BEAT_W'(n - 1) : '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_seq_cnt
//  Description : Loadable down-counter with enable and zero flag. It times
//                the beat, pause and row-gap phases of the sequencer.
//  Ports       : clk        in   clock
//                reset      in   synchronous active-high reset (count -> 0)
//                load_i     in   load load_val_i (has priority over en_i)
//                load_val_i in   W-bit preload value
//                en_i       in   decrement when count is non-zero
//                cnt_o      out  current count
//                zero_o     out  count == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_seq_cnt
  import pixel_seq_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_beat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_beat_sequencer
//  Description : Raster pixel-address sequencer for the filter datapath.
//                Walks an IMG_W x IMG_H window of a frame buffer with pitch
//                ROW_PITCH. Each pixel gets BEATS process cycles followed by
//                PAUSE idle cycles; ROW_GAP idle cycles separate rows. A
//                downstream stall freezes the whole sequencer.
//  Ports       : clk           in   clock
//                reset         in   synchronous active-high reset
//                start_i       in   begin a frame (sampled only in IDLE)
//                stall_i       in   downstream not ready; freezes sequencer
//                process_o     out  pixel_addr_o / beat_idx_o valid
//                busy_o        out  frame in progress
//                done_o        out  one-cycle pulse after the last pixel
//                pixel_addr_o  out  current pixel address
//                x_o / y_o     out  current column / row
//                beat_idx_o    out  beat within the pixel, 0..BEATS-1
//                row_start_o   out  first beat of the first pixel of a row
//                frame_last_o  out  last beat of the last pixel of the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_beat_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          COORD_W   = DEF_COORD_W,
  parameter int          IMG_W     = DEF_IMG_W,
  parameter int          IMG_H     = DEF_IMG_H,
  parameter int          ROW_PITCH = DEF_ROW_PITCH,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int          BEATS     = DEF_BEATS,
  parameter int          PAUSE     = DEF_PAUSE,
  parameter int          ROW_GAP   = DEF_ROW_GAP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               stall_i,
  output logic               process_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_W-1:0]  pixel_addr_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [BEAT_W-1:0]  beat_idx_o,
  output logic               row_start_o,
  output logic               frame_last_o
);

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - 1);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]  PAUSE_LD  = cnt_preload(PAUSE);
  localparam logic [BEAT_W-1:0]  GAP_LD    = cnt_preload(ROW_GAP);
  localparam logic [ADDR_W-1:0]  BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0]  PITCH     = ADDR_W'(ROW_PITCH);

  seq_state_e         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;

  logic              w_beat_ld, w_beat_en, w_beat_zero;
  logic              w_pause_ld, w_pause_en, w_pause_zero;
  logic              w_gap_ld, w_gap_en, w_gap_zero;
  logic [BEAT_W-1:0] w_beat_cnt, w_pause_cnt, w_gap_cnt;
  logic              w_adv;
  logic [BEAT_W-1:0] w_beat_idx;

  // Beat counter counts down from BEATS-1; the beat index is its complement.
  pixel_seq_cnt #(.W(BEAT_W)) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_beat_ld),
    .load_val_i (BEAT_LAST),
    .en_i       (w_beat_en),
    .cnt_o      (w_beat_cnt),
    .zero_o     (w_beat_zero)
  );

  pixel_seq_cnt #(.W(BEAT_W)) u_pause_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_pause_ld),
    .load_val_i (PAUSE_LD),
    .en_i       (w_pause_en),
    .cnt_o      (w_pause_cnt),
    .zero_o     (w_pause_zero)
  );

  pixel_seq_cnt #(.W(BEAT_W)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (w_gap_ld),
    .load_val_i (GAP_LD),
    .en_i       (w_gap_en),
    .cnt_o      (w_gap_cnt),
    .zero_o     (w_gap_zero)
  );

  // Only the zero flags of the idle counters steer the FSM.
  logic w_unused_cnt;
  assign w_unused_cnt = ^{w_pause_cnt, w_gap_cnt};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    w_beat_ld  = 1'b0;
    w_beat_en  = 1'b0;
    w_pause_ld = 1'b0;
    w_pause_en = 1'b0;
    w_gap_ld   = 1'b0;
    w_gap_en   = 1'b0;
    w_adv      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_BEAT;
          x_d        = '0;
          y_d        = '0;
          addr_d     = BASE;
          row_base_d = BASE;
          w_beat_ld  = 1'b1;
        end
      end
      ST_BEAT: begin
        if (!stall_i) begin
          if (!w_beat_zero) begin
            w_beat_en = 1'b1;
          end else if (PAUSE > 0) begin
            state_d    = ST_PAUSE;
            w_pause_ld = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (!stall_i) begin
          if (!w_pause_zero) begin
            w_pause_en = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (!stall_i) begin
          if (!w_gap_zero) begin
            w_gap_en = 1'b1;
          end else begin
            state_d   = ST_BEAT;
            w_beat_ld = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Step to the next pixel once the current one has finished its beats
    // and pause. Row changes jump from the tracked row base so that any
    // pitch larger than the window width is honoured.
    if (w_adv) begin
      if (x_q != X_LAST) begin
        x_d       = x_q + COORD_W'(1);
        addr_d    = addr_q + ADDR_W'(1);
        state_d   = ST_BEAT;
        w_beat_ld = 1'b1;
      end else if (y_q != Y_LAST) begin
        x_d        = '0;
        y_d        = y_q + COORD_W'(1);
        addr_d     = row_base_q + PITCH;
        row_base_d = row_base_q + PITCH;
        if (ROW_GAP > 0) begin
          state_d  = ST_GAP;
          w_gap_ld = 1'b1;
        end else begin
          state_d   = ST_BEAT;
          w_beat_ld = 1'b1;
        end
      end else begin
        state_d = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= BASE;
      row_base_q <= BASE;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
    end
  end

  // Beat index reads 0 outside BEAT so the idle value matches reset.
  assign w_beat_idx   = (state_q == ST_BEAT) ? (BEAT_LAST - w_beat_cnt) : '0;

  assign process_o    = (state_q == ST_BEAT) && !stall_i;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign pixel_addr_o = addr_q;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign beat_idx_o   = w_beat_idx;
  assign row_start_o  = process_o && (x_q == '0) && (w_beat_idx == '0);
  assign frame_last_o = process_o && (x_q == X_LAST) && (y_q == Y_LAST) &&
                        (w_beat_idx == BEAT_LAST);

endmodule
`default_nettype wire
